// File: rtl/mul_rs.sv
// Three-entry reservation station for the multiply/divide unit: holds issued
// instructions until both operands are valid, then dispatches them one at a time.
module mul_rs #(
  parameter int DATA_W = 8,
  parameter int TAG_W  = 3,
  parameter int REG_W  = 4
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [3:0]        iss_func,
  input  logic [REG_W-1:0]  iss_rd,
  input  logic [TAG_W-1:0]  iss_rob,
  input  logic              iss_r1,
  input  logic              iss_r2,
  input  logic [DATA_W-1:0] iss_v1,
  input  logic [DATA_W-1:0] iss_v2,
  input  logic [TAG_W-1:0]  iss_q1,
  input  logic [TAG_W-1:0]  iss_q2,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              ex_busy,
  output logic              ex_b,
  output logic [DATA_W-1:0] ex_rs1_data,
  output logic [DATA_W-1:0] ex_rs2_data,
  output logic [3:0]        ex_func,
  output logic [REG_W-1:0]  ex_rd,
  output logic [TAG_W-1:0]  ex_rob_ind,
  output logic [2:0]        ex_rs_index,
  input  logic              ex_done,
  input  logic [2:0]        ex_done_index,
  output logic [1:0]        rs_count,
  input  logic              flush
);

  localparam int N = 3;

  typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_READY, ST_EXEC} st_e;

  st_e               st_q   [N];
  st_e               st_d   [N];
  logic [3:0]        func_q [N];
  logic [3:0]        func_d [N];
  logic [REG_W-1:0]  rd_q   [N];
  logic [REG_W-1:0]  rd_d   [N];
  logic [TAG_W-1:0]  rob_q  [N];
  logic [TAG_W-1:0]  rob_d  [N];
  logic              r1_q   [N];
  logic              r1_d   [N];
  logic              r2_q   [N];
  logic              r2_d   [N];
  logic [DATA_W-1:0] v1_q   [N];
  logic [DATA_W-1:0] v1_d   [N];
  logic [DATA_W-1:0] v2_q   [N];
  logic [DATA_W-1:0] v2_d   [N];
  logic [TAG_W-1:0]  q1_q   [N];
  logic [TAG_W-1:0]  q1_d   [N];
  logic [TAG_W-1:0]  q2_q   [N];
  logic [TAG_W-1:0]  q2_d   [N];

  logic              ex_b_q, ex_b_d;
  logic [DATA_W-1:0] ex_rs1_q, ex_rs1_d;
  logic [DATA_W-1:0] ex_rs2_q, ex_rs2_d;
  logic [3:0]        ex_func_q, ex_func_d;
  logic [REG_W-1:0]  ex_rd_q, ex_rd_d;
  logic [TAG_W-1:0]  ex_rob_q, ex_rob_d;
  logic [2:0]        ex_idx_q, ex_idx_d;
  logic [1:0]        cnt_q, cnt_d;

  logic       any_exec, any_ready, any_free;
  logic [1:0] disp_idx, alloc_idx;
  logic       dispatch_fire, iss_fire;
  logic       byp_r1, byp_r2;
  logic [DATA_W-1:0] byp_v1, byp_v2;

  // Descending scan so the lowest-index match is the one that sticks.
  always_comb begin
    any_exec  = 1'b0;
    any_ready = 1'b0;
    any_free  = 1'b0;
    disp_idx  = 2'd0;
    alloc_idx = 2'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (st_q[i] == ST_EXEC) any_exec = 1'b1;
      if (st_q[i] == ST_READY) begin
        any_ready = 1'b1;
        disp_idx  = 2'(i);
      end
      if (st_q[i] == ST_FREE) begin
        any_free  = 1'b1;
        alloc_idx = 2'(i);
      end
    end
  end

  assign dispatch_fire = !any_exec && !ex_busy && any_ready;
  assign iss_fire      = iss_valid && any_free;

  assign byp_r1 = iss_r1 || (cdb_valid && (iss_q1 == cdb_tag));
  assign byp_r2 = iss_r2 || (cdb_valid && (iss_q2 == cdb_tag));
  assign byp_v1 = iss_r1 ? iss_v1 : cdb_data;
  assign byp_v2 = iss_r2 ? iss_v2 : cdb_data;

  // Wakeup, done, dispatch and allocation touch disjoint entry states, so
  // they can be applied independently per entry.
  always_comb begin
    st_d      = st_q;
    func_d    = func_q;
    rd_d      = rd_q;
    rob_d     = rob_q;
    r1_d      = r1_q;
    r2_d      = r2_q;
    v1_d      = v1_q;
    v2_d      = v2_q;
    q1_d      = q1_q;
    q2_d      = q2_q;
    ex_b_d    = 1'b0;
    ex_rs1_d  = ex_rs1_q;
    ex_rs2_d  = ex_rs2_q;
    ex_func_d = ex_func_q;
    ex_rd_d   = ex_rd_q;
    ex_rob_d  = ex_rob_q;
    ex_idx_d  = ex_idx_q;
    cnt_d     = 2'd0;
    if (flush) begin
      for (int i = 0; i < N; i++) st_d[i] = ST_FREE;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (st_q[i] == ST_WAIT) begin
          if (cdb_valid && !r1_q[i] && (q1_q[i] == cdb_tag)) begin
            r1_d[i] = 1'b1;
            v1_d[i] = cdb_data;
          end
          if (cdb_valid && !r2_q[i] && (q2_q[i] == cdb_tag)) begin
            r2_d[i] = 1'b1;
            v2_d[i] = cdb_data;
          end
          if (r1_d[i] && r2_d[i]) st_d[i] = ST_READY;
        end
        if (ex_done && (ex_done_index == 3'(i)) && (st_q[i] == ST_EXEC))
          st_d[i] = ST_FREE;
        if (dispatch_fire && (disp_idx == 2'(i))) begin
          st_d[i]   = ST_EXEC;
          ex_b_d    = 1'b1;
          ex_rs1_d  = v1_q[i];
          ex_rs2_d  = v2_q[i];
          ex_func_d = func_q[i];
          ex_rd_d   = rd_q[i];
          ex_rob_d  = rob_q[i];
          ex_idx_d  = 3'(i);
        end
        if (iss_fire && (alloc_idx == 2'(i))) begin
          st_d[i]   = (byp_r1 && byp_r2) ? ST_READY : ST_WAIT;
          func_d[i] = iss_func;
          rd_d[i]   = iss_rd;
          rob_d[i]  = iss_rob;
          r1_d[i]   = byp_r1;
          r2_d[i]   = byp_r2;
          v1_d[i]   = byp_v1;
          v2_d[i]   = byp_v2;
          q1_d[i]   = iss_q1;
          q2_d[i]   = iss_q2;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (st_d[i] != ST_FREE) cnt_d = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        st_q[i]   <= ST_FREE;
        func_q[i] <= '0;
        rd_q[i]   <= '0;
        rob_q[i]  <= '0;
        r1_q[i]   <= 1'b0;
        r2_q[i]   <= 1'b0;
        v1_q[i]   <= '0;
        v2_q[i]   <= '0;
        q1_q[i]   <= '0;
        q2_q[i]   <= '0;
      end
      ex_b_q    <= 1'b0;
      ex_rs1_q  <= '0;
      ex_rs2_q  <= '0;
      ex_func_q <= '0;
      ex_rd_q   <= '0;
      ex_rob_q  <= '0;
      ex_idx_q  <= '0;
      cnt_q     <= '0;
    end else begin
      st_q      <= st_d;
      func_q    <= func_d;
      rd_q      <= rd_d;
      rob_q     <= rob_d;
      r1_q      <= r1_d;
      r2_q      <= r2_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      q1_q      <= q1_d;
      q2_q      <= q2_d;
      ex_b_q    <= ex_b_d;
      ex_rs1_q  <= ex_rs1_d;
      ex_rs2_q  <= ex_rs2_d;
      ex_func_q <= ex_func_d;
      ex_rd_q   <= ex_rd_d;
      ex_rob_q  <= ex_rob_d;
      ex_idx_q  <= ex_idx_d;
      cnt_q     <= cnt_d;
    end
  end

  assign iss_ready   = any_free;
  assign ex_b        = ex_b_q;
  assign ex_rs1_data = ex_rs1_q;
  assign ex_rs2_data = ex_rs2_q;
  assign ex_func     = ex_func_q;
  assign ex_rd       = ex_rd_q;
  assign ex_rob_ind  = ex_rob_q;
  assign ex_rs_index = ex_idx_q;
  assign rs_count    = cnt_q;

endmodule
